// File: rtl/sample_path_arbiter_if.sv
// Request/sample bus between the fast-domain sources and the crossing-register arbiter.
// master = arbiter side (grants, drives the crossing register); slave = the sources side.
interface sample_path_arbiter_if #(
    parameter int NCH = 4,
    parameter int DW  = 12,
    parameter int CW  = $clog2(NCH)
);
    logic [NCH-1:0]    req_valid;
    logic [NCH*DW-1:0] req_data;
    logic [NCH-1:0]    req_ready;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_chan;
    logic              out_load;

    modport master (
        input  req_valid,
        input  req_data,
        output req_ready,
        output out_data,
        output out_chan,
        output out_load
    );

    modport slave (
        output req_valid,
        output req_data,
        input  req_ready,
        input  out_data,
        input  out_chan,
        input  out_load
    );
endinterface

// File: rtl/sample_path_arbiter.sv
// Round-robin share of the 12-bit fast->slow crossing register; req_ready 1 cycle, out_load 2 cycles after slot_tick.
// Sources hold req_valid until granted; one tick queues while busy, a further one sets overrun (SAMPLE_ARB_OVR_COUNT_EN adds ovr_count).
module sample_path_arbiter #(
    parameter int NCH = 4,
    parameter int DW  = 12,
    parameter int CW  = $clog2(NCH)
) (
    input  logic                         fast_clk,
    input  logic                         reset_n,
    input  logic                         slot_tick,
    sample_path_arbiter_if.master        bus,
    output logic                         busy,
    output logic                         overrun,
    input  logic                         ovr_clr,
    output logic [7:0]                   ovr_count
);

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        GRANT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            pending;
    logic            pending_nxt;
    logic            tick_lost;
    logic [CW-1:0]   last_grant;
    logic            grant_found;
    logic [CW-1:0]   grant_idx;
    logic [CW-1:0]   cand_idx;
    int              cand;
    logic [NCH-1:0]  req_ready_c;
    logic            out_load_c;
    logic [DW-1:0]   out_data_q;
    logic [CW-1:0]   out_chan_q;
    logic [DW-1:0]   chan_data [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign chan_data[g] = bus.req_data[g*DW +: DW];
    end

    // Search starts just after the last winner so every source gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand     = (int'(last_grant) + i) % NCH;
            cand_idx = CW'(cand);
            if (!grant_found && bus.req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        req_ready_c = '0;
        out_load_c  = 1'b0;
        tick_lost   = 1'b0;
        case (state)
            WAIT: begin
                if (slot_tick || pending) begin
                    state_nxt   = GRANT;
                    pending_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (grant_found) begin
                    req_ready_c[grant_idx] = 1'b1;
                    state_nxt              = LOAD;
                end else begin
                    state_nxt = WAIT;
                end
            end
            LOAD: begin
                out_load_c = 1'b1;
                state_nxt  = WAIT;
            end
            default: state_nxt = WAIT;
        endcase
        // Only one tick can be queued behind an in-flight transfer.
        if ((state != WAIT) && slot_tick) begin
            if (pending) begin
                tick_lost = 1'b1;
            end else begin
                pending_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT;
            pending    <= 1'b0;
            last_grant <= CW'(NCH - 1);
            out_data_q <= '0;
            out_chan_q <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if ((state == GRANT) && grant_found) begin
                out_data_q <= chan_data[grant_idx];
                out_chan_q <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

    // A loss in the same cycle as a clear must stay visible.
    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (tick_lost) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

`ifdef SAMPLE_ARB_OVR_COUNT_EN
    logic [7:0] ovr_cnt_q;

    always_ff @(posedge fast_clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr_cnt_q <= 8'd0;
        end else if (tick_lost) begin
            if (ovr_clr) begin
                ovr_cnt_q <= 8'd1;
            end else if (ovr_cnt_q != 8'hFF) begin
                ovr_cnt_q <= ovr_cnt_q + 8'd1;
            end
        end else if (ovr_clr) begin
            ovr_cnt_q <= 8'd0;
        end
    end

    assign ovr_count = ovr_cnt_q;
`else
    assign ovr_count = 8'd0;
`endif

    assign bus.req_ready = req_ready_c;
    assign bus.out_load  = out_load_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign busy          = (state != WAIT);

endmodule

// File: tb/tb_sample_path_arbiter.sv
// Bench for sample_path_arbiter: directed plan steps followed by random ticks/requests against a slot-level model.
module tb_sample_path_arbiter;
    localparam int NCH = 4;
    localparam int DW  = 12;
    localparam int CW  = $clog2(NCH);

    logic       fast_clk  = 1'b0;
    logic       reset_n   = 1'b0;
    logic       slot_tick = 1'b0;
    logic       ovr_clr   = 1'b0;
    logic       busy;
    logic       overrun;
    logic [7:0] ovr_count;

    int total = 0;
    int bad   = 0;

    // Reference model: age of the transfer in flight (-1 none, 0 grant cycle, 1 load cycle)
    int            m_age;
    bit            m_pend;
    int            m_last;
    logic [DW-1:0] m_data;
    int            m_chan;
    bit            m_ovr;
    int            m_cnt;

    sample_path_arbiter_if #(.NCH(NCH), .DW(DW), .CW(CW)) bus ();

    sample_path_arbiter #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
        .fast_clk  (fast_clk),
        .reset_n   (reset_n),
        .slot_tick (slot_tick),
        .bus       (bus),
        .busy      (busy),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr),
        .ovr_count (ovr_count)
    );

    always #5 fast_clk = ~fast_clk;

    function automatic int rr_pick(input int last, input logic [NCH-1:0] v);
        for (int k = 1; k <= NCH; k++) begin
            if (v[(last + k) % NCH]) return (last + k) % NCH;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_age  = -1;
        m_pend = 1'b0;
        m_last = NCH - 1;
        m_data = '0;
        m_chan = 0;
        m_ovr  = 1'b0;
        m_cnt  = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        int w;
        bit lost;
        if (!reset_n) begin
            model_reset();
            return;
        end
        lost = 1'b0;
        if (m_age < 0) begin
            if (slot_tick || m_pend) begin
                m_age  = 0;
                m_pend = 1'b0;
            end
        end else begin
            if (slot_tick) begin
                if (m_pend) lost = 1'b1;
                else        m_pend = 1'b1;
            end
            if (m_age == 0) begin
                w = rr_pick(m_last, bus.req_valid);
                if (w >= 0) begin
                    m_data = bus.req_data[w*DW +: DW];
                    m_chan = w;
                    m_last = w;
                    m_age  = 1;
                end else begin
                    m_age = -1;
                end
            end else begin
                m_age = -1;
            end
        end
        if (lost) begin
            m_ovr = 1'b1;
            m_cnt = ovr_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (ovr_clr) begin
            m_ovr = 1'b0;
            m_cnt = 0;
        end
    endtask

    task automatic check_all(input string tag);
        int w;
        logic [NCH-1:0] rr_exp;
        int exp_cnt;
        rr_exp = '0;
        if (m_age == 0) begin
            w = rr_pick(m_last, bus.req_valid);
            if (w >= 0) rr_exp = NCH'(1 << w);
        end
`ifdef SAMPLE_ARB_OVR_COUNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(rr_exp));
        chk({tag, ".out_load"},  32'(bus.out_load),  32'(m_age == 1));
        chk({tag, ".out_data"},  32'(bus.out_data),  32'(m_data));
        chk({tag, ".out_chan"},  32'(bus.out_chan),  32'(m_chan));
        chk({tag, ".busy"},      32'(busy),          32'(m_age >= 0));
        chk({tag, ".overrun"},   32'(overrun),       32'(m_ovr));
        chk({tag, ".ovr_count"}, 32'(ovr_count),     32'(exp_cnt));
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge fast_clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_all_valid();
        bus.req_valid = '1;
        for (int c = 0; c < NCH; c++) bus.req_data[c*DW +: DW] = DW'(12'h100 + c);
    endtask

    initial begin
        int nb;
        int nl;
        int nr;
        int exp_ovc;
        bus.req_valid = '0;
        bus.req_data  = '0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) cycle("reset_hold");
        reset_n = 1'b1;

        // Tick with nothing valid: one busy cycle, no grant, no load
        slot_tick = 1'b1;
        cycle("empty_tick");
        slot_tick = 1'b0;
        nb = int'(busy); nl = int'(bus.out_load); nr = (bus.req_ready != 0) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            cycle("empty_idle");
            nb += int'(busy); nl += int'(bus.out_load); nr += (bus.req_ready != 0) ? 1 : 0;
        end
        chk("empty.busy_cycles", 32'(nb), 32'd1);
        chk("empty.loads", 32'(nl), 32'd0);
        chk("empty.grants", 32'(nr), 32'd0);
        chk("empty.out_data", 32'(bus.out_data), 32'h000);

        // All valid: four ticks rotate through ch0..ch3
        set_all_valid();
        for (int k = 0; k < NCH; k++) begin
            slot_tick = 1'b1;
            cycle("rr_tick");
            slot_tick = 1'b0;
            chk("rr.req_ready", 32'(bus.req_ready), 32'(1 << k));
            cycle("rr_load");
            chk("rr.out_load", 32'(bus.out_load), 32'd1);
            chk("rr.out_data", 32'(bus.out_data), 32'h100 + 32'(k));
            chk("rr.out_chan", 32'(bus.out_chan), 32'(k));
            repeat (8) cycle("rr_idle");
        end

        // Only ch2 valid, then ch0+ch2 with search starting at ch3
        bus.req_valid = 4'b0100;
        bus.req_data[2*DW +: DW] = 12'hABC;
        slot_tick = 1'b1;
        cycle("ch2_tick");
        slot_tick = 1'b0;
        cycle("ch2_load");
        chk("ch2.out_chan", 32'(bus.out_chan), 32'd2);
        chk("ch2.out_data", 32'(bus.out_data), 32'hABC);
        repeat (3) cycle("ch2_idle");
        bus.req_valid = 4'b0101;
        slot_tick = 1'b1;
        cycle("wrap_tick");
        slot_tick = 1'b0;
        chk("wrap.req_ready", 32'(bus.req_ready), 32'b0001);
        cycle("wrap_load");
        chk("wrap.out_chan", 32'(bus.out_chan), 32'd0);
        repeat (3) cycle("wrap_idle");

        // Back-to-back ticks: second one queued, both serviced
        set_all_valid();
        nl = 0;
        slot_tick = 1'b1;
        cycle("b2b_t0"); nl += int'(bus.out_load);
        cycle("b2b_t1"); nl += int'(bus.out_load);
        slot_tick = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle("b2b_idle"); nl += int'(bus.out_load);
        end
        chk("b2b.loads", 32'(nl), 32'd2);
        chk("b2b.overrun", 32'(overrun), 32'd0);

        // Three ticks in a row: third is lost
        slot_tick = 1'b1;
        repeat (3) cycle("lose_tick");
        slot_tick = 1'b0;
        repeat (6) cycle("lose_idle");
`ifdef SAMPLE_ARB_OVR_COUNT_EN
        exp_ovc = 1;
`else
        exp_ovc = 0;
`endif
        chk("lose.overrun", 32'(overrun), 32'd1);
        chk("lose.ovr_count", 32'(ovr_count), 32'(exp_ovc));
        ovr_clr = 1'b1;
        cycle("clr");
        ovr_clr = 1'b0;
        chk("clr.overrun", 32'(overrun), 32'd0);
        chk("clr.ovr_count", 32'(ovr_count), 32'd0);

        // Asynchronous reset while in GRANT
        slot_tick = 1'b1;
        cycle("arst_tick");
        slot_tick = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        chk("arst.req_ready", 32'(bus.req_ready), 32'd0);
        chk("arst.out_load", 32'(bus.out_load), 32'd0);
        chk("arst.out_data", 32'(bus.out_data), 32'd0);
        repeat (2) cycle("arst_hold");
        reset_n = 1'b1;
        slot_tick = 1'b1;
        cycle("arst_rel_tick");
        slot_tick = 1'b0;
        chk("arst_rel.req_ready", 32'(bus.req_ready), 32'b0001);
        cycle("arst_rel_load");
        chk("arst_rel.out_data", 32'(bus.out_data), 32'h100);
        repeat (3) cycle("arst_rel_idle");

        // ch1 drops req_valid before its grant cycle
        bus.req_valid = 4'b0010;
        slot_tick = 1'b1;
        cycle("drop_tick");
        slot_tick = 1'b0;
        bus.req_valid = 4'b0000;
        #1;
        check_all("drop_grant");
        chk("drop.req_ready", 32'(bus.req_ready), 32'd0);
        cycle("drop_after");
        chk("drop.out_load", 32'(bus.out_load), 32'd0);
        chk("drop.busy", 32'(busy), 32'd0);
        chk("drop.out_data", 32'(bus.out_data), 32'h100);
        repeat (2) cycle("drop_idle");

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            slot_tick     = ($urandom_range(0, 99) < 35);
            ovr_clr       = ($urandom_range(0, 99) < 4);
            bus.req_valid = NCH'($urandom);
            for (int c = 0; c < NCH; c++) bus.req_data[c*DW +: DW] = DW'($urandom);
            cycle("rand");
        end
        slot_tick = 1'b0;
        ovr_clr   = 1'b0;
        repeat (4) cycle("drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
